// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch front end; owns the PC, sequences a program run
// from a req/done handshake and counts run cycles. Rev 1.0
`default_nettype none

module fetch_sequencer #(
    parameter int D        = 12,
    parameter int OW       = 8,
    parameter int PROG_END = 128,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          halt,
    input  logic          absjump_en,
    input  logic [D-1:0]  target,
    input  logic          reljump_en,
    input  logic [OW-1:0] offset,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic [D-1:0]  w_offset_ext;

    assign w_offset_ext = {{(D-OW){offset[OW-1]}}, offset};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        running_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (req) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    running_d = 1'b1;
                end
            end
            RUN: begin
                running_d = 1'b1;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CW'(1);
                // Stall masks halt and jumps; control re-presents them once released.
                if (stall) begin
                    pc_d = pc_q;
                end else if (halt || (pc_q == D'(PROG_END))) begin
                    state_d   = DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end else if (absjump_en) begin
                    pc_d = target;
                end else if (reljump_en) begin
                    pc_d = pc_q + w_offset_ext;
                end else begin
                    pc_d = pc_q + D'(1);
                end
            end
            DONE: begin
                if (req) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign prog_ctr  = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign cycle_cnt = cnt_q;

endmodule

`default_nettype wire
